// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for exception_ctrl: cause codes and FSM state encoding.
package exception_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  localparam logic [31:0] EXCEPT_NONE      = 32'h0000_0000;
  localparam logic [31:0] EXCEPT_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXCEPT_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXCEPT_ILLEGAL   = 32'h0000_000a;
  localparam logic [31:0] EXCEPT_OVERFLOW  = 32'h0000_000c;
  localparam logic [31:0] EXCEPT_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXCEPT_ERET      = 32'h0000_000e;

  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/exception_ctrl_int_sync.sv
// int_sync: two-flop synchronizer for the external interrupt lines (used with EXC_INT_SYNC_EN).
module int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: prioritises MEM-stage causes, flushes the pipeline, then redirects the PC.
// Optional macro EXC_INT_SYNC_EN puts hardware_int through a 2-flop synchronizer.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] HANDLER_VECTOR = DATA_WIDTH'(32'h0000_0040),
  parameter int                    FLUSH_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_pc,
  input  logic                  exc_syscall,
  input  logic                  exc_illegal,
  input  logic                  exc_trap,
  input  logic                  exc_overflow,
  input  logic                  exc_eret,
  input  logic [5:0]            hardware_int,
  input  logic                  timer_interrupt,
  input  logic [31:0]           status,
  input  logic [31:0]           cause,
  input  logic [DATA_WIDTH-1:0] epc,
  output logic [31:0]           exception,
  output logic [DATA_WIDTH-1:0] exc_pc,
  output logic                  flush,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] new_pc,
  output logic                  new_pc_valid
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_CYCLES);

  logic [5:0]  w_hw;
  logic [7:0]  w_ip;
  logic        w_int_req;
  logic [31:0] w_sel_code;
  logic        w_take;
  logic        w_unused;

`ifdef EXC_INT_SYNC_EN
  int_sync #(.WIDTH(6)) u_int_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (hardware_int),
    .o_sync  (w_hw)
  );
`else
  assign w_hw = hardware_int;
`endif

  // The timer shares IP7 with hardware line 5 and is never synchronized.
  assign w_ip      = {w_hw[5] | timer_interrupt, w_hw[4:0], cause[9:8]};
  assign w_int_req = status[0] & ~status[1] & (|(w_ip & status[15:8]));
  assign w_unused  = ^{status[31:16], status[7:2], cause[31:10], cause[7:0]};

  always_comb begin
    w_sel_code = EXCEPT_NONE;
    if (w_int_req)         w_sel_code = EXCEPT_INTERRUPT;
    else if (exc_illegal)  w_sel_code = EXCEPT_ILLEGAL;
    else if (exc_overflow) w_sel_code = EXCEPT_OVERFLOW;
    else if (exc_trap)     w_sel_code = EXCEPT_TRAP;
    else if (exc_syscall)  w_sel_code = EXCEPT_SYSCALL;
    else if (exc_eret)     w_sel_code = EXCEPT_ERET;
  end

  assign w_take = mem_valid & (w_sel_code != EXCEPT_NONE);

  exc_state_e              r_state;
  logic [FLUSH_CNT_W-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0]   r_target;
  logic [31:0]             r_exception;
  logic [DATA_WIDTH-1:0]   r_exc_pc;
  logic                    r_flush;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_new_pc;
  logic                    r_new_pc_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_target       <= '0;
      r_exception    <= EXCEPT_NONE;
      r_exc_pc       <= '0;
      r_flush        <= 1'b0;
      r_busy         <= 1'b0;
      r_new_pc       <= '0;
      r_new_pc_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_exception    <= EXCEPT_NONE;
          r_flush        <= 1'b0;
          r_busy         <= 1'b0;
          r_new_pc_valid <= 1'b0;
          if (w_take) begin
            r_state     <= ST_FLUSH;
            r_cnt       <= FLUSH_CNT_W'(1);
            r_exception <= w_sel_code;
            r_exc_pc    <= mem_pc;
            r_flush     <= 1'b1;
            r_busy      <= 1'b1;
            r_target    <= (w_sel_code == EXCEPT_ERET) ? epc : HANDLER_VECTOR;
          end
        end
        ST_FLUSH: begin
          // The cause code is a single-cycle strobe to CP0.
          r_exception <= EXCEPT_NONE;
          if (r_cnt == FLUSH_LAST) begin
            r_state        <= ST_REDIRECT;
            r_flush        <= 1'b0;
            r_new_pc       <= r_target;
            r_new_pc_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + FLUSH_CNT_W'(1);
          end
        end
        ST_REDIRECT: begin
          r_state        <= ST_IDLE;
          r_busy         <= 1'b0;
          r_new_pc_valid <= 1'b0;
        end
        default: begin
          r_state        <= ST_IDLE;
          r_exception    <= EXCEPT_NONE;
          r_flush        <= 1'b0;
          r_busy         <= 1'b0;
          r_new_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign exception    = r_exception;
  assign exc_pc       = r_exc_pc;
  assign flush        = r_flush;
  assign busy         = r_busy;
  assign new_pc       = r_new_pc;
  assign new_pc_valid = r_new_pc_valid;

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed scenarios plus random traffic, scoreboard against a cycle-count model.
module tb_exception_ctrl;
  import exception_ctrl_pkg::*;

  localparam int          FC = 2;
  localparam logic [31:0] HV = 32'h0000_0040;
`ifdef EXC_INT_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_pc = '0;
  logic        exc_syscall = 1'b0, exc_illegal = 1'b0, exc_trap = 1'b0;
  logic        exc_overflow = 1'b0, exc_eret = 1'b0;
  logic [5:0]  hardware_int = '0;
  logic        timer_interrupt = 1'b0;
  logic [31:0] status = '0, cause = '0, epc = '0;
  logic [31:0] exception, exc_pc, new_pc;
  logic        flush, busy, new_pc_valid;

  exception_ctrl #(.DATA_WIDTH(32), .HANDLER_VECTOR(HV), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .exc_syscall(exc_syscall), .exc_illegal(exc_illegal), .exc_trap(exc_trap),
    .exc_overflow(exc_overflow), .exc_eret(exc_eret), .hardware_int(hardware_int),
    .timer_interrupt(timer_interrupt), .status(status), .cause(cause), .epc(epc),
    .exception(exception), .exc_pc(exc_pc), .flush(flush), .busy(busy),
    .new_pc(new_pc), .new_pc_valid(new_pc_valid)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard state
  typedef struct { int at; logic [31:0] code; logic [31:0] pc; } exc_t;
  typedef struct { int at; logic [31:0] pc; } red_t;
  exc_t exc_q[$];
  red_t red_q[$];
  int errors = 0;
  int checks = 0;
  int acc_at = -1000;
  int free_at = 0;
  logic [31:0] hold_exc = '0, hold_new = '0;
  logic [5:0]  hw_p1 = '0, hw_p2 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: cause selection straight from the priority rules
  function automatic logic [31:0] ref_code(input logic [5:0] hw);
    logic [7:0] ip;
    logic       irq;
    ip  = {hw[5] | timer_interrupt, hw[4:0], cause[9:8]};
    irq = status[0] && !status[1] && ((ip & status[15:8]) != 8'h0);
    if (irq)          return EXCEPT_INTERRUPT;
    if (exc_illegal)  return EXCEPT_ILLEGAL;
    if (exc_overflow) return EXCEPT_OVERFLOW;
    if (exc_trap)     return EXCEPT_TRAP;
    if (exc_syscall)  return EXCEPT_SYSCALL;
    if (exc_eret)     return EXCEPT_ERET;
    return EXCEPT_NONE;
  endfunction

  // driver: inputs are already set; predict the next edge, then advance one cycle
  task automatic commit();
    int          n;
    logic [5:0]  hw_eff;
    logic [31:0] code;
    n      = cyc + 1;
    hw_eff = SYNC_EN ? hw_p2 : hardware_int;
    hw_p2  = hw_p1;
    hw_p1  = rst_n ? hardware_int : 6'h0;
    if (rst_n && mem_valid && n >= free_at) begin
      code = ref_code(hw_eff);
      if (code != EXCEPT_NONE) begin
        acc_at  = n;
        free_at = n + FC + 2;
        exc_q.push_back('{at: n, code: code, pc: mem_pc});
        red_q.push_back('{at: n + FC, pc: (code == EXCEPT_ERET) ? epc : HV});
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid = 0; exc_syscall = 0; exc_illegal = 0; exc_trap = 0;
    exc_overflow = 0; exc_eret = 0; hardware_int = '0; timer_interrupt = 0;
  endtask

  task automatic idle(input int k);
    clear_inputs();
    repeat (k) commit();
  endtask

  task automatic model_reset();
    exc_q.delete();
    red_q.delete();
    acc_at = -1000; free_at = 0;
    hold_exc = '0; hold_new = '0;
    hw_p1 = '0; hw_p2 = '0;
  endtask

  // monitor: pops an expectation whenever the DUT strobes a cause or a redirect
  always @(negedge clk) begin : monitor
    int   m;
    exc_t e;
    red_t r;
    m = cyc;
    if (exception != EXCEPT_NONE) begin
      if (exc_q.size() == 0) chk("exc_unexpected", exception, EXCEPT_NONE);
      else begin
        e = exc_q.pop_front();
        chk("exc_code", exception, e.code);
        chk("exc_pc", exc_pc, e.pc);
        chk("exc_time", m, e.at);
        hold_exc = e.pc;
      end
    end else if (exc_q.size() != 0 && exc_q[0].at <= m) begin
      e = exc_q.pop_front();
      chk("exc_missing", exception, e.code);
      hold_exc = e.pc;
    end
    if (new_pc_valid) begin
      if (red_q.size() == 0) chk("redirect_unexpected", 32'(new_pc_valid), 32'h0);
      else begin
        r = red_q.pop_front();
        chk("new_pc", new_pc, r.pc);
        chk("redirect_time", m, r.at);
        hold_new = r.pc;
      end
    end else if (red_q.size() != 0 && red_q[0].at <= m) begin
      r = red_q.pop_front();
      chk("redirect_missing", 32'(new_pc_valid), 32'h1);
      hold_new = r.pc;
    end
    chk("flush", 32'(flush), 32'(m >= acc_at && m <= acc_at + FC - 1));
    chk("busy", 32'(busy), 32'(m >= acc_at && m <= acc_at + FC));
    if (!new_pc_valid) chk("new_pc_hold", new_pc, hold_new);
    if (exception == EXCEPT_NONE) chk("exc_pc_hold", exc_pc, hold_exc);
  end

  initial begin
    clear_inputs();
    repeat (3) commit();
    chk("reset_exception", exception, 32'h0);
    chk("reset_new_pc", new_pc, 32'h0);
    rst_n = 1;
    idle(2);

    // syscall then eret
    mem_valid = 1; exc_syscall = 1; mem_pc = 32'h100; commit();
    idle(FC + 3);
    mem_valid = 1; exc_eret = 1; epc = 32'h2004; mem_pc = 32'h180; commit();
    idle(FC + 3);

    // interrupt beats overflow; with EXL set the overflow wins
    status = 32'h0000_1001; hardware_int = 6'b000100; commit(); commit();
    mem_valid = 1; exc_overflow = 1; mem_pc = 32'h300; commit();
    mem_valid = 0; exc_overflow = 0; commit();
    idle(FC + 3);
    status = 32'h0000_1003; hardware_int = 6'b000100; commit(); commit();
    mem_valid = 1; exc_overflow = 1; mem_pc = 32'h304; commit();
    idle(FC + 3);

    // trap arriving during FLUSH/REDIRECT is dropped
    status = 32'h0;
    mem_valid = 1; exc_syscall = 1; mem_pc = 32'h400; commit();
    exc_syscall = 0; exc_trap = 1; mem_pc = 32'h404; repeat (FC + 1) commit();
    idle(FC + 3);

    // reset during FLUSH
    mem_valid = 1; exc_illegal = 1; mem_pc = 32'h500; commit();
    clear_inputs();
    rst_n = 0;
    #1;
    chk("async_rst_flush", 32'(flush), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_exception", exception, 32'h0);
    model_reset();
    commit(); commit();
    rst_n = 1;
    idle(FC + 4);

    // timer request versus the same request on hardware_int[5]
    status = 32'h0000_8001;
    mem_valid = 1; timer_interrupt = 1; mem_pc = 32'h600; commit();
    timer_interrupt = 0; mem_valid = 0; idle(FC + 3);
    mem_valid = 1; hardware_int = 6'b100000; mem_pc = 32'h604;
    repeat (3) commit();
    idle(FC + 4);

    // masked or disabled interrupts stay quiet
    status = 32'h0000_0101; mem_valid = 1; hardware_int = 6'h3f; cause = 32'h0; repeat (4) commit();
    status = 32'h0000_ff00; repeat (4) commit();
    idle(3);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      mem_valid       = ($urandom_range(0, 3) != 0);
      exc_syscall     = ($urandom_range(0, 7) == 0);
      exc_illegal     = ($urandom_range(0, 9) == 0);
      exc_trap        = ($urandom_range(0, 9) == 0);
      exc_overflow    = ($urandom_range(0, 9) == 0);
      exc_eret        = ($urandom_range(0, 7) == 0);
      hardware_int    = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h0;
      timer_interrupt = ($urandom_range(0, 15) == 0);
      status          = {16'h0, 8'($urandom), 6'h0,
                         1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0)};
      cause           = $urandom & 32'h0000_0300;
      mem_pc          = $urandom & 32'hffff_fffc;
      epc             = $urandom & 32'hffff_fffc;
      commit();
    end
    idle(FC + 6);

    chk("exc_q_drained", 32'(exc_q.size()), 32'h0);
    chk("red_q_drained", 32'(red_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
